// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch control: next-PC select, syscall halt/resume via a
// synchronised Go button, and run statistics counters.
module pc_fetch_ctrl #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [31:0] CONT_CODE = 32'h0000_0022
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Order,
    input  logic [31:0] R1_out,
    input  logic [31:0] Ext18,
    input  logic        Branch_taken,
    input  logic        Jmp,
    input  logic        Jal,
    input  logic        Jr,
    input  logic        Syscall,
    input  logic        Go,
    output logic [31:0] PC,
    output logic [31:0] PC_plus_4,
    output logic        Halted,
    output logic [31:0] Cycle_cnt,
    output logic [31:0] Instr_cnt,
    output logic [31:0] Branch_cnt,
    output logic [31:0] Jump_cnt
);

    localparam int unsigned W = 32;

    typedef enum logic {S_RUN, S_HALT} state_t;

    state_t         r_state;
    logic [W-1:0]   r_pc;
    logic           r_halted;
    logic [W-1:0]   r_cycle_cnt;
    logic [W-1:0]   r_instr_cnt;
    logic [W-1:0]   r_branch_cnt;
    logic [W-1:0]   r_jump_cnt;
    logic           r_g1;
    logic           r_g2;
    logic           r_g3;

    logic [W-1:0]   w_pc_plus_4;
    logic [W-1:0]   w_next_pc;
    logic           w_halt_req;
    logic           w_go_edge;
    logic           w_retire;
    logic           w_is_jump;
    logic           w_unused_order;

    assign w_unused_order = ^Order[31:26];
    assign w_pc_plus_4    = r_pc + W'(4);
    assign w_go_edge      = r_g2 & ~r_g3;
    assign w_halt_req     = Syscall && (R1_out != CONT_CODE);
    assign w_is_jump      = Jmp | Jal | Jr;

    // Next-PC select for a retiring instruction in RUN; Jr outranks everything.
    always_comb begin
        w_next_pc = w_pc_plus_4;
        if (Jr) begin
            w_next_pc = R1_out;
        end else if (Jmp || Jal) begin
            w_next_pc = {w_pc_plus_4[31:28], Order[25:0], 2'b00};
        end else if (Branch_taken) begin
            w_next_pc = w_pc_plus_4 + Ext18;
        end
    end

    // A halted syscall retires only when the resume edge arrives.
    always_comb begin
        w_retire = 1'b0;
        if (r_state == S_RUN) begin
            w_retire = !w_halt_req;
        end else begin
            w_retire = w_go_edge;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_RUN;
            r_pc         <= PC_RESET;
            r_halted     <= 1'b0;
            r_cycle_cnt  <= '0;
            r_instr_cnt  <= '0;
            r_branch_cnt <= '0;
            r_jump_cnt   <= '0;
            r_g1         <= 1'b1;
            r_g2         <= 1'b1;
            r_g3         <= 1'b1;
        end else begin
            r_g1 <= Go;
            r_g2 <= r_g1;
            r_g3 <= r_g2;

            if (r_state == S_RUN) begin
                r_cycle_cnt <= r_cycle_cnt + W'(1);
                if (w_halt_req) begin
                    r_state  <= S_HALT;
                    r_halted <= 1'b1;
                end else begin
                    r_pc <= w_next_pc;
                end
            end else if (w_go_edge) begin
                r_state  <= S_RUN;
                r_halted <= 1'b0;
                r_pc     <= w_pc_plus_4;
            end

            if (w_retire) begin
                r_instr_cnt <= r_instr_cnt + W'(1);
                if (Branch_taken) begin
                    r_branch_cnt <= r_branch_cnt + W'(1);
                end
                if (w_is_jump) begin
                    r_jump_cnt <= r_jump_cnt + W'(1);
                end
            end
        end
    end

    assign PC         = r_pc;
    assign PC_plus_4  = w_pc_plus_4;
    assign Halted     = r_halted;
    assign Cycle_cnt  = r_cycle_cnt;
    assign Instr_cnt  = r_instr_cnt;
    assign Branch_cnt = r_branch_cnt;
    assign Jump_cnt   = r_jump_cnt;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed vector table, hand-written halt/resume
// sequences, and randomized stimulus against a behavioural model.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] PCR  = 32'h0000_3000;
    localparam logic [31:0] CONT = 32'h0000_0022;

    logic        clk;
    logic        rst;
    logic [31:0] Order, R1_out, Ext18;
    logic        Branch_taken, Jmp, Jal, Jr, Syscall, Go;
    logic [31:0] PC, PC_plus_4;
    logic        Halted;
    logic [31:0] Cycle_cnt, Instr_cnt, Branch_cnt, Jump_cnt;

    pc_fetch_ctrl #(.PC_RESET(PCR), .CONT_CODE(CONT)) dut (
        .clk(clk), .rst(rst), .Order(Order), .R1_out(R1_out), .Ext18(Ext18),
        .Branch_taken(Branch_taken), .Jmp(Jmp), .Jal(Jal), .Jr(Jr),
        .Syscall(Syscall), .Go(Go), .PC(PC), .PC_plus_4(PC_plus_4),
        .Halted(Halted), .Cycle_cnt(Cycle_cnt), .Instr_cnt(Instr_cnt),
        .Branch_cnt(Branch_cnt), .Jump_cnt(Jump_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] order;
        logic [31:0] r1;
        logic [31:0] ext;
        logic        br, jmp, jal, jr, sys, go;
    } vin_t;

    typedef struct {
        vin_t        in;
        logic [31:0] exp_pc;
        logic        exp_halted;
        logic [31:0] exp_instr;
        logic [31:0] exp_cycle;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] m_pc, m_cyc, m_ins, m_br, m_jmp;
    logic        m_halt;
    logic        m_go_hist [3];

    function automatic vin_t mk(input logic r, input logic [31:0] order,
                                input logic [31:0] r1, input logic [31:0] ext,
                                input logic br, input logic jmp, input logic jal,
                                input logic jr, input logic sys, input logic go);
        vin_t v;
        v.rst = r; v.order = order; v.r1 = r1; v.ext = ext;
        v.br = br; v.jmp = jmp; v.jal = jal; v.jr = jr; v.sys = sys; v.go = go;
        return v;
    endfunction

    function automatic vin_t seq(input logic go);
        return mk(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, go);
    endfunction

    function automatic vin_t sys_halt(input logic go);
        return mk(1'b0, 32'h0, 32'h0000_000A, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, go);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input vin_t v);
        logic        edge_seen;
        logic        retire;
        logic [31:0] nxt;
        logic [31:0] plus4;
        if (v.rst) begin
            m_pc = PCR; m_halt = 1'b0;
            m_cyc = 0; m_ins = 0; m_br = 0; m_jmp = 0;
            m_go_hist[0] = 1'b1; m_go_hist[1] = 1'b1; m_go_hist[2] = 1'b1;
        end else begin
            edge_seen = m_go_hist[1] && !m_go_hist[2];
            retire = 1'b0;
            nxt = m_pc;
            plus4 = m_pc + 32'd4;
            if (!m_halt) begin
                m_cyc = m_cyc + 1;
                if (v.sys && v.r1 != CONT) begin
                    m_halt = 1'b1;
                end else begin
                    retire = 1'b1;
                    if (v.jr)                nxt = v.r1;
                    else if (v.jmp || v.jal) nxt = (plus4 & 32'hF000_0000) | ((v.order & 32'h03FF_FFFF) << 2);
                    else if (v.br)           nxt = plus4 + v.ext;
                    else                     nxt = plus4;
                end
            end else if (edge_seen) begin
                m_halt = 1'b0;
                retire = 1'b1;
                nxt = plus4;
            end
            if (retire) begin
                m_ins = m_ins + 1;
                if (v.br) m_br = m_br + 1;
                if (v.jmp || v.jal || v.jr) m_jmp = m_jmp + 1;
                m_pc = nxt;
            end
            m_go_hist[2] = m_go_hist[1];
            m_go_hist[1] = m_go_hist[0];
            m_go_hist[0] = v.go;
        end
    endtask

    task automatic check_model();
        chk("model_pc", PC, m_pc);
        chk("model_pc_plus_4", PC_plus_4, m_pc + 32'd4);
        chk("model_halted", {31'b0, Halted}, {31'b0, m_halt});
        chk("model_cycle_cnt", Cycle_cnt, m_cyc);
        chk("model_instr_cnt", Instr_cnt, m_ins);
        chk("model_branch_cnt", Branch_cnt, m_br);
        chk("model_jump_cnt", Jump_cnt, m_jmp);
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check after it.
    task automatic step(input vin_t v);
        rst = v.rst; Order = v.order; R1_out = v.r1; Ext18 = v.ext;
        Branch_taken = v.br; Jmp = v.jmp; Jal = v.jal; Jr = v.jr;
        Syscall = v.sys; Go = v.go;
        @(posedge clk);
        model_update(v);
        #1;
        check_model();
    endtask

    vec_t tbl [11];

    initial begin
        logic go_lvl;
        vin_t v;
        int   r;

        tbl[0]  = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0),                          32'h3000, 0, 0, 0};
        tbl[1]  = '{seq(0),                                                    32'h3004, 0, 1, 1};
        tbl[2]  = '{seq(0),                                                    32'h3008, 0, 2, 2};
        tbl[3]  = '{seq(0),                                                    32'h300C, 0, 3, 3};
        tbl[4]  = '{mk(0, 0, 32'h100, 0, 0, 0, 0, 1, 0, 0),                    32'h0100, 0, 4, 4};
        tbl[5]  = '{mk(0, 0, 0, 32'hFFFF_FFF0, 1, 0, 0, 0, 0, 0),              32'h00F4, 0, 5, 5};
        tbl[6]  = '{mk(0, 32'h0000_0040, 0, 0, 0, 0, 1, 0, 0, 0),              32'h0100, 0, 6, 6};
        tbl[7]  = '{mk(0, 0, 32'h200, 32'h40, 1, 0, 0, 1, 0, 0),               32'h0200, 0, 7, 7};
        tbl[8]  = '{mk(0, 0, 32'h22, 0, 0, 0, 0, 0, 1, 0),                     32'h0204, 0, 8, 8};
        tbl[9]  = '{mk(0, 0, 32'h40, 0, 0, 0, 0, 1, 0, 0),                     32'h0040, 0, 9, 9};
        tbl[10] = '{sys_halt(0),                                               32'h0040, 1, 9, 10};

        for (int i = 0; i < 11; i++) begin
            if (i == 6) chk("jal_pc_plus_4", PC_plus_4, 32'h0000_00F8);
            step(tbl[i].in);
            chk($sformatf("tbl%0d_pc", i), PC, tbl[i].exp_pc);
            chk($sformatf("tbl%0d_halted", i), {31'b0, Halted}, {31'b0, tbl[i].exp_halted});
            chk($sformatf("tbl%0d_instr", i), Instr_cnt, tbl[i].exp_instr);
            chk($sformatf("tbl%0d_cycle", i), Cycle_cnt, tbl[i].exp_cycle);
        end
        chk("branch_cnt_after_table", Branch_cnt, 32'd2);
        chk("jump_cnt_after_table", Jump_cnt, 32'd4);

        // Halted for 50 cycles: PC and Cycle_cnt frozen.
        for (int i = 0; i < 50; i++) step(sys_halt(0));
        chk("halt_hold_pc", PC, 32'h40);
        chk("halt_cycle_frozen", Cycle_cnt, 32'd10);

        // Four-cycle Go pulse: one resume at the third sampling edge.
        for (int k = 0; k < 4; k++) begin
            step(k < 3 ? sys_halt(1) : seq(1));
            chk($sformatf("pulse%0d_halted", k), {31'b0, Halted}, (k < 2) ? 32'd1 : 32'd0);
        end
        chk("resume_pc", PC, 32'h48);
        chk("resume_instr", Instr_cnt, 32'd11);
        for (int i = 0; i < 4; i++) step(seq(0));

        // Go held across a halt: no resume until release and re-press.
        for (int i = 0; i < 4; i++) step(seq(1));
        step(sys_halt(1));
        for (int i = 0; i < 10; i++) step(sys_halt(1));
        chk("held_go_no_resume", {31'b0, Halted}, 32'd1);
        for (int i = 0; i < 4; i++) step(sys_halt(0));
        chk("released_still_halted", {31'b0, Halted}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            step(sys_halt(1));
            chk($sformatf("repress%0d_halted", k), {31'b0, Halted}, (k < 2) ? 32'd1 : 32'd0);
        end
        step(seq(0));

        // Reset while halted with Go held.
        step(sys_halt(1));
        step(sys_halt(1));
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        chk("rst_halt_pc", PC, PCR);
        chk("rst_halt_halted", {31'b0, Halted}, 32'd0);
        chk("rst_halt_instr", Instr_cnt, 32'd0);
        chk("rst_halt_cycle", Cycle_cnt, 32'd0);
        step(seq(1));
        chk("post_rst_pc", PC, 32'h3004);

        // Address wrap and jump region boundaries.
        step(mk(0, 0, 32'hFFFF_FFFC, 0, 0, 0, 0, 1, 0, 0));
        step(seq(0));
        chk("pc_wrap", PC, 32'h0000_0000);
        step(mk(0, 0, 32'h7FFF_FFF8, 0, 0, 0, 0, 1, 0, 0));
        step(mk(0, 32'hFC00_0010, 0, 0, 0, 1, 0, 0, 0, 0));
        chk("jmp_region", PC, 32'h7000_0040);
        step(mk(0, 0, 0, 32'h8FFF_FFC0, 1, 0, 0, 0, 0, 0));
        chk("branch_wrap", PC, 32'h0000_0004);

        // Randomized run against the model.
        go_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) go_lvl = ~go_lvl;
            r = int'($urandom_range(0, 9));
            v.rst   = ($urandom_range(0, 299) == 0);
            v.order = $urandom;
            v.r1    = ($urandom_range(0, 1) == 0) ? CONT : $urandom;
            v.ext   = $urandom;
            v.br    = ($urandom_range(0, 3) == 0);
            v.jmp   = (r == 1);
            v.jal   = (r == 2);
            v.jr    = (r == 3) || ($urandom_range(0, 15) == 0);
            v.sys   = ($urandom_range(0, 5) == 0);
            v.go    = go_lvl;
            step(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
